// File: rtl/controller_pkg.sv
// Shared types and constants for the multi-identity ENTDAA responder.
// Device word layout, reserved-address byte, FSM state encoding and parity helper.
package controller_pkg;

    localparam int unsigned DevWordW   = 64;
    localparam logic [6:0]  RsvdAddr   = 7'h7E;
    localparam logic [7:0]  RsvdByteRd = {RsvdAddr, 1'b1};

    typedef enum logic [3:0] {
        Idle,
        WaitStart,
        ReceiveRsvdByte,
        Select,
        AckRsvdByte,
        SendIdBit,
        ReceiveAddr,
        AckAddr,
        SendNack,
        Passive,
        Done
    } state_e;

    function automatic logic [DevWordW-1:0] dev_word(input logic [47:0] pid,
                                                     input logic [7:0]  bcr,
                                                     input logic [7:0]  dcr);
        return {pid, bcr, dcr};
    endfunction

    // Bit 0 carries odd parity over the 7 address bits.
    function automatic logic addr_parity_ok(input logic [7:0] b);
        return b[0] == ~^b[7:1];
    endfunction

endpackage

// File: rtl/ccc_entdaa_multi_if.sv
// Bus-side handshake bundle between the ENTDAA responder and the TX/RX engines and bus monitor.
// master = responder (issues requests), slave = bus engines (report done / bus events).
interface ccc_entdaa_multi_if;
    logic [7:0] bus_rx_data_i;
    logic       bus_rx_done_i;
    logic       bus_rx_req_byte_o;
    logic       bus_tx_done_i;
    logic       bus_tx_req_bit_o;
    logic [7:0] bus_tx_req_value_o;
    logic       bus_tx_sel_od_pp_o;
    logic       bus_rstart_det_i;
    logic       bus_stop_det_i;
    logic       arbitration_lost_i;

    modport master (
        input  bus_rx_data_i, bus_rx_done_i, bus_tx_done_i,
               bus_rstart_det_i, bus_stop_det_i, arbitration_lost_i,
        output bus_rx_req_byte_o, bus_tx_req_bit_o, bus_tx_req_value_o, bus_tx_sel_od_pp_o
    );

    modport slave (
        output bus_rx_data_i, bus_rx_done_i, bus_tx_done_i,
               bus_rstart_det_i, bus_stop_det_i, arbitration_lost_i,
        input  bus_rx_req_byte_o, bus_tx_req_bit_o, bus_tx_req_value_o, bus_tx_sel_od_pp_o
    );
endinterface

// File: rtl/daa_id_select.sv
// Sequential lowest-device-word scanner: one identity per cycle, index 0 first, ties keep lower index.
// done/valid/idx are combinational in the cycle that scans the last identity (NumTargets cycles after start).
module daa_id_select
    import controller_pkg::*;
#(
    parameter int unsigned NumTargets = 2,
    parameter int unsigned IdxW       = 1
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               start_i,
    input  logic [NumTargets-1:0][DevWordW-1:0] word_i,
    input  logic [NumTargets-1:0]              eligible_i,
    output logic                               done_o,
    output logic                               valid_o,
    output logic [IdxW-1:0]                    idx_o
);

    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumTargets - 1);

    logic                r_busy;
    logic [IdxW-1:0]     r_cnt;
    logic                r_best_vld;
    logic [IdxW-1:0]     r_best_idx;
    logic [DevWordW-1:0] r_best_word;

    logic            w_active;
    logic [IdxW-1:0] w_idx;
    logic            w_have;
    logic            w_take;

    // start_i scans index 0 in its own cycle so a new scan ignores any stale best.
    always_comb begin
        w_active = start_i | r_busy;
        w_idx    = start_i ? '0 : r_cnt;
        w_have   = start_i ? 1'b0 : r_best_vld;
        w_take   = w_active && eligible_i[w_idx] &&
                   (!w_have || (word_i[w_idx] < r_best_word));
        done_o   = w_active && (w_idx == LastIdx);
        valid_o  = w_take | w_have;
        idx_o    = w_take ? w_idx : r_best_idx;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_busy      <= 1'b0;
            r_cnt       <= '0;
            r_best_vld  <= 1'b0;
            r_best_idx  <= '0;
            r_best_word <= '0;
        end else if (w_active) begin
            r_busy     <= !done_o;
            r_cnt      <= w_idx + 1'b1;
            r_best_vld <= valid_o;
            if (w_take) begin
                r_best_idx  <= w_idx;
                r_best_word <= word_i[w_idx];
            end
        end
    end

endmodule

// File: rtl/ccc_entdaa_multi.sv
// Multi-identity ENTDAA responder: wins DAA rounds for the lowest unassigned device word, one identity per round.
// ACK request NumTargets cycles after the 0xFD byte; each bus request holds until its done and drops the cycle after.
module ccc_entdaa_multi
    import controller_pkg::*;
#(
    parameter int unsigned NumTargets = 2,
    parameter int unsigned IdxW       = (NumTargets > 1) ? $clog2(NumTargets) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumTargets-1:0][47:0]   id_i,
    input  logic [NumTargets-1:0][7:0]    bcr_i,
    input  logic [NumTargets-1:0][7:0]    dcr_i,
    input  logic [NumTargets-1:0]         enable_i,
    input  logic                          clear_assigned_i,
    input  logic                          start_daa_i,
    output logic                          done_daa_o,
    output logic [NumTargets-1:0]         assigned_o,
    output logic [6:0]                    address_o,
    output logic [IdxW-1:0]               address_idx_o,
    output logic                          address_valid_o,
    ccc_entdaa_multi_if.master            bus
);

    state_e              r_state;
    logic [NumTargets-1:0] r_assigned;
    logic [6:0]          r_cnt;
    logic [IdxW-1:0]     r_cand_idx;
    logic [DevWordW-1:0] r_word;

    state_e                             w_state_d;
    logic [NumTargets-1:0][DevWordW-1:0] w_words;
    logic                               w_sel_start;
    logic                               w_sel_done;
    logic                               w_sel_valid;
    logic [IdxW-1:0]                    w_sel_idx;
    logic                               w_latch;
    logic                               w_bit;

    always_comb begin
        for (int i = 0; i < int'(NumTargets); i++) begin
            w_words[i] = dev_word(id_i[i], bcr_i[i], dcr_i[i]);
        end
    end

    daa_id_select #(
        .NumTargets (NumTargets),
        .IdxW       (IdxW)
    ) u_select (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (w_sel_start),
        .word_i     (w_words),
        .eligible_i (enable_i & ~r_assigned),
        .done_o     (w_sel_done),
        .valid_o    (w_sel_valid),
        .idx_o      (w_sel_idx)
    );

    // r_cnt counts 64..1; the low six bits minus one wrap 64 onto bit 63.
    assign w_bit                  = r_word[r_cnt[5:0] - 6'd1];
    assign assigned_o             = r_assigned;
    assign bus.bus_tx_sel_od_pp_o = 1'b0;

    always_comb begin
        w_state_d              = r_state;
        w_sel_start            = 1'b0;
        w_latch                = 1'b0;
        bus.bus_rx_req_byte_o  = 1'b0;
        bus.bus_tx_req_bit_o   = 1'b0;
        bus.bus_tx_req_value_o = '0;
        done_daa_o             = 1'b0;
        address_valid_o        = 1'b0;
        address_o              = '0;
        address_idx_o          = '0;

        case (r_state)
            Idle: if (start_daa_i) w_state_d = WaitStart;
            WaitStart: if (bus.bus_rstart_det_i) w_state_d = ReceiveRsvdByte;
            ReceiveRsvdByte: begin
                bus.bus_rx_req_byte_o = 1'b1;
                if (bus.bus_rx_done_i) begin
                    if (bus.bus_rx_data_i == RsvdByteRd) begin
                        w_sel_start = 1'b1;
                        // A single identity finishes its scan in this same cycle.
                        if (w_sel_done) begin
                            w_latch   = w_sel_valid;
                            w_state_d = w_sel_valid ? AckRsvdByte : Passive;
                        end else begin
                            w_state_d = Select;
                        end
                    end else begin
                        w_state_d = Passive;
                    end
                end
            end
            Select: begin
                if (w_sel_done) begin
                    w_latch   = w_sel_valid;
                    w_state_d = w_sel_valid ? AckRsvdByte : Passive;
                end
            end
            AckRsvdByte: begin
                bus.bus_tx_req_bit_o = 1'b1;
                if (bus.bus_tx_done_i) w_state_d = SendIdBit;
            end
            SendIdBit: begin
                bus.bus_tx_req_bit_o   = 1'b1;
                bus.bus_tx_req_value_o = {7'b0, w_bit};
                if (bus.bus_tx_done_i) begin
                    if (bus.arbitration_lost_i) w_state_d = WaitStart;
                    else if (r_cnt == 7'd1)     w_state_d = ReceiveAddr;
                end
            end
            ReceiveAddr: begin
                bus.bus_rx_req_byte_o = 1'b1;
                if (bus.bus_rx_done_i) begin
                    if (addr_parity_ok(bus.bus_rx_data_i)) begin
                        address_valid_o = 1'b1;
                        address_o       = bus.bus_rx_data_i[7:1];
                        address_idx_o   = r_cand_idx;
                        w_state_d       = AckAddr;
                    end else begin
                        w_state_d = SendNack;
                    end
                end
            end
            AckAddr: begin
                bus.bus_tx_req_bit_o = 1'b1;
                if (bus.bus_tx_done_i) w_state_d = WaitStart;
            end
            SendNack: begin
                bus.bus_tx_req_bit_o   = 1'b1;
                bus.bus_tx_req_value_o = 8'h01;
                if (bus.bus_tx_done_i) w_state_d = WaitStart;
            end
            Passive: ;
            Done: begin
                done_daa_o = 1'b1;
                w_state_d  = Idle;
            end
            default: w_state_d = Idle;
        endcase

        // Done itself is excluded so a lingering Stop cannot produce a second pulse.
        if (bus.bus_stop_det_i && (r_state != Idle) && (r_state != Done)) w_state_d = Done;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= Idle;
            r_assigned <= '0;
            r_cnt      <= '0;
            r_cand_idx <= '0;
            r_word     <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_latch) begin
                r_cand_idx <= w_sel_idx;
                r_word     <= w_words[w_sel_idx];
            end
            if (r_state == AckRsvdByte && bus.bus_tx_done_i) begin
                r_cnt <= 7'(DevWordW);
            end else if (r_state == SendIdBit && bus.bus_tx_done_i) begin
                r_cnt <= r_cnt - 7'd1;
            end
            if (r_state == Idle && clear_assigned_i) begin
                r_assigned <= '0;
            end else if (r_state == AckAddr && bus.bus_tx_done_i && !bus.bus_stop_det_i) begin
                r_assigned[r_cand_idx] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ccc_entdaa_multi.sv
// Directed bench for ccc_entdaa_multi with two identities; the bench plays the bus engines and monitor.
module tb_ccc_entdaa_multi;
    localparam int N    = 2;
    localparam int IdxW = 1;
    localparam logic [63:0] W0 = 64'h0000_1111_2222_1020;
    localparam logic [63:0] W1 = 64'h0000_3333_4444_1121;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic [N-1:0][47:0]    id_i;
    logic [N-1:0][7:0]     bcr_i;
    logic [N-1:0][7:0]     dcr_i;
    logic [N-1:0]          enable_i;
    logic                  clear_assigned_i;
    logic                  start_daa_i;
    logic                  done_daa_o;
    logic [N-1:0]          assigned_o;
    logic [6:0]            address_o;
    logic [IdxW-1:0]       address_idx_o;
    logic                  address_valid_o;

    ccc_entdaa_multi_if bus_if ();

    ccc_entdaa_multi #(.NumTargets(N)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .id_i             (id_i),
        .bcr_i            (bcr_i),
        .dcr_i            (dcr_i),
        .enable_i         (enable_i),
        .clear_assigned_i (clear_assigned_i),
        .start_daa_i      (start_daa_i),
        .done_daa_o       (done_daa_o),
        .assigned_o       (assigned_o),
        .address_o        (address_o),
        .address_idx_o    (address_idx_o),
        .address_valid_o  (address_valid_o),
        .bus              (bus_if)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;
    int av_cnt  = 0;
    int done_cnt = 0;
    int tx_cnt  = 0;

    always @(posedge clk_i) begin
        if (address_valid_o === 1'b1)         av_cnt++;
        if (done_daa_o === 1'b1)              done_cnt++;
        if (bus_if.bus_tx_req_bit_o === 1'b1) tx_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tx();
        int k = 0;
        while (bus_if.bus_tx_req_bit_o !== 1'b1 && k < 100) begin
            @(negedge clk_i);
            k++;
        end
        chk("tx_req_seen", bus_if.bus_tx_req_bit_o, 1);
    endtask

    task automatic wait_rx();
        int k = 0;
        while (bus_if.bus_rx_req_byte_o !== 1'b1 && k < 100) begin
            @(negedge clk_i);
            k++;
        end
        chk("rx_req_seen", bus_if.bus_rx_req_byte_o, 1);
    endtask

    task automatic tx_bit(input logic lose, output logic [7:0] v);
        wait_tx();
        v = bus_if.bus_tx_req_value_o;
        bus_if.bus_tx_done_i      = 1'b1;
        bus_if.arbitration_lost_i = lose;
        @(negedge clk_i);
        bus_if.bus_tx_done_i      = 1'b0;
        bus_if.arbitration_lost_i = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b, output logic av,
                           output logic [6:0] a, output logic [IdxW-1:0] ai);
        wait_rx();
        bus_if.bus_rx_data_i = b;
        bus_if.bus_rx_done_i = 1'b1;
        #1;
        av = address_valid_o;
        a  = address_o;
        ai = address_idx_o;
        @(negedge clk_i);
        bus_if.bus_rx_done_i = 1'b0;
    endtask

    task automatic sr();
        bus_if.bus_rstart_det_i = 1'b1;
        @(negedge clk_i);
        bus_if.bus_rstart_det_i = 1'b0;
    endtask

    task automatic start_frame();
        start_daa_i = 1'b1;
        @(negedge clk_i);
        start_daa_i = 1'b0;
    endtask

    task automatic stop_frame();
        bus_if.bus_stop_det_i = 1'b1;
        @(negedge clk_i);
        bus_if.bus_stop_det_i = 1'b0;
        chk("done_pulse", done_daa_o, 1);
        @(negedge clk_i);
        chk("done_one_cycle", done_daa_o, 0);
    endtask

    // Sends bits 63 downward; lose_at >= 0 raises arbitration_lost_i on that bit and stops there.
    task automatic send_id(input logic [63:0] exp_w, input int lose_at, input string tag);
        logic [63:0] rec = '0;
        logic [7:0]  v;
        int          lo;
        for (int i = 63; i >= 0; i--) begin
            tx_bit(i == lose_at, v);
            rec[i] = v[0];
            if (i == lose_at) break;
        end
        lo = (lose_at < 0) ? 0 : lose_at;
        chk(tag, rec >> lo, exp_w >> lo);
    endtask

    task automatic daa_round(input logic [63:0] w, input logic [7:0] ab,
                             input logic exp_ok, input logic [IdxW-1:0] exp_idx);
        logic            av;
        logic [6:0]      a;
        logic [IdxW-1:0] ai;
        logic [7:0]      v;
        logic [6:0]      exp_a;
        sr();
        rx_byte(8'hFD, av, a, ai);
        // N=2: select occupies one more cycle, ACK request in the second cycle after the byte.
        chk("sel_latency_n_minus_1", bus_if.bus_tx_req_bit_o, 0);
        @(negedge clk_i);
        chk("sel_latency_n", bus_if.bus_tx_req_bit_o, 1);
        tx_bit(1'b0, v);
        chk("ack_rsvd_value", v, 8'h00);
        send_id(w, -1, "id_word");
        rx_byte(ab, av, a, ai);
        exp_a = ab[7:1];
        chk("addr_valid", av, exp_ok);
        chk("addr_value", a, exp_ok ? exp_a : 7'h00);
        chk("addr_idx", ai, exp_ok ? exp_idx : '0);
        tx_bit(1'b0, v);
        chk("addr_ack_value", v, {7'b0, ~exp_ok});
    endtask

    initial begin
        logic            av;
        logic [6:0]      a;
        logic [IdxW-1:0] ai;
        logic [7:0]      v;
        int              c0;
        int              d0;

        rst_ni = 1'b1;
        id_i[0] = 48'h0000_1111_2222; bcr_i[0] = 8'h10; dcr_i[0] = 8'h20;
        id_i[1] = 48'h0000_3333_4444; bcr_i[1] = 8'h11; dcr_i[1] = 8'h21;
        enable_i = '0;
        clear_assigned_i = 1'b0;
        start_daa_i = 1'b0;
        bus_if.bus_rx_data_i = '0;
        bus_if.bus_rx_done_i = 1'b0;
        bus_if.bus_tx_done_i = 1'b0;
        bus_if.bus_rstart_det_i = 1'b0;
        bus_if.bus_stop_det_i = 1'b0;
        bus_if.arbitration_lost_i = 1'b0;
        #2 rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);

        chk("rst_done", done_daa_o, 0);
        chk("rst_assigned", assigned_o, 0);
        chk("rst_rx_req", bus_if.bus_rx_req_byte_o, 0);
        chk("rst_tx_req", bus_if.bus_tx_req_bit_o, 0);
        chk("rst_tx_value", bus_if.bus_tx_req_value_o, 0);
        chk("rst_od_pp", bus_if.bus_tx_sel_od_pp_o, 0);
        chk("rst_addr_valid", address_valid_o, 0);
        chk("rst_addr", address_o, 0);
        rst_ni = 1'b1;
        enable_i = 2'b11;
        @(negedge clk_i);

        // Two rounds in one frame: identity 0 (lower word) first, then identity 1.
        start_frame();
        daa_round(W0, 8'h13, 1'b1, 1'b0);
        chk("assigned_after_r1", assigned_o, 2'b01);
        daa_round(W1, 8'h23, 1'b1, 1'b1);
        chk("assigned_after_r2", assigned_o, 2'b11);
        d0 = done_cnt;
        stop_frame();
        chk("done_count_frame1", done_cnt - d0, 1);

        // All assigned: clear ignored outside Idle, 0xFD leads to a silent Passive.
        start_frame();
        clear_assigned_i = 1'b1;
        @(negedge clk_i);
        clear_assigned_i = 1'b0;
        chk("clear_ignored_waitstart", assigned_o, 2'b11);
        sr();
        c0 = tx_cnt;
        rx_byte(8'hFD, av, a, ai);
        repeat (8) @(negedge clk_i);
        chk("all_assigned_no_tx", tx_cnt - c0, 0);
        chk("all_assigned_no_rx", bus_if.bus_rx_req_byte_o, 0);
        stop_frame();
        clear_assigned_i = 1'b1;
        @(negedge clk_i);
        clear_assigned_i = 1'b0;
        chk("clear_in_idle", assigned_o, 2'b00);

        // Arbitration lost at bit 40, then a full retry on the next Sr.
        start_frame();
        sr();
        rx_byte(8'hFD, av, a, ai);
        tx_bit(1'b0, v);
        chk("arb_ack_value", v, 8'h00);
        send_id(W0, 40, "arb_partial_word");
        chk("arb_no_tx", bus_if.bus_tx_req_bit_o, 0);
        chk("arb_no_rx", bus_if.bus_rx_req_byte_o, 0);
        chk("arb_unassigned", assigned_o, 2'b00);
        daa_round(W0, 8'h13, 1'b1, 1'b0);
        chk("arb_retry_assigned", assigned_o, 2'b01);
        stop_frame();

        // Bad parity for address 0x11: NACK, nothing assigned, no valid strobe.
        start_frame();
        c0 = av_cnt;
        daa_round(W1, 8'h22, 1'b0, 1'b0);
        chk("bad_parity_assigned", assigned_o, 2'b01);
        chk("bad_parity_no_valid", av_cnt - c0, 0);
        stop_frame();

        // Non-ENTDAA first byte: Passive until Stop, one done pulse.
        start_frame();
        sr();
        c0 = tx_cnt;
        d0 = done_cnt;
        rx_byte(8'h7C, av, a, ai);
        repeat (5) @(negedge clk_i);
        chk("passive_rx_idle", bus_if.bus_rx_req_byte_o, 0);
        stop_frame();
        repeat (3) @(negedge clk_i);
        chk("passive_no_tx", tx_cnt - c0, 0);
        chk("passive_done_count", done_cnt - d0, 1);

        // Stop together with tx done in AckAddr: identity stays unassigned.
        clear_assigned_i = 1'b1;
        @(negedge clk_i);
        clear_assigned_i = 1'b0;
        chk("clear_before_stop_race", assigned_o, 2'b00);
        start_frame();
        sr();
        rx_byte(8'hFD, av, a, ai);
        tx_bit(1'b0, v);
        send_id(W0, -1, "race_id_word");
        rx_byte(8'h13, av, a, ai);
        chk("race_addr_valid", av, 1);
        wait_tx();
        chk("race_ack_value", bus_if.bus_tx_req_value_o, 8'h00);
        bus_if.bus_tx_done_i  = 1'b1;
        bus_if.bus_stop_det_i = 1'b1;
        @(negedge clk_i);
        bus_if.bus_tx_done_i  = 1'b0;
        bus_if.bus_stop_det_i = 1'b0;
        chk("race_done_pulse", done_daa_o, 1);
        chk("race_not_assigned", assigned_o, 2'b00);
        @(negedge clk_i);

        // Reset asserted mid-ID drops every request at once.
        start_frame();
        sr();
        rx_byte(8'hFD, av, a, ai);
        tx_bit(1'b0, v);
        for (int i = 0; i < 5; i++) tx_bit(1'b0, v);
        chk("mid_id_tx_req", bus_if.bus_tx_req_bit_o, 1);
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_tx_req", bus_if.bus_tx_req_bit_o, 0);
        chk("rst_mid_tx_value", bus_if.bus_tx_req_value_o, 0);
        chk("rst_mid_rx_req", bus_if.bus_rx_req_byte_o, 0);
        chk("rst_mid_done", done_daa_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
